// File: rtl/bpred_fetch_mems_if.sv
// ----------------------------------------------------------------------------
// bpred_fetch_mems_if
//   Groups the signals that connect the fetch-stage storage to the predictor.
//   The predictor owns the master side. It drives both write ports and both
//   read addresses, and it receives the registered read data.
//   The memories own the slave side.
//
//   Signals (widths follow the parameters):
//     insn_wren, insn_wraddress, insn_data, insn_rdaddress -> instruction RAM
//     insn_q                                               <- instruction RAM
//     btb_wren, btb_byteena, btb_wraddress, btb_data,
//     btb_rdaddress                                        -> BTB/bimodal RAM
//     btb_q                                                <- BTB/bimodal RAM
//
//   Transfer semantics: there is no valid/ready handshake. A write that is
//   presented with its wren high at a rising clock edge completes on that
//   edge. A read address that is presented at an edge returns its data on q
//   after that edge. The RAMs never stall and never back-pressure.
// ----------------------------------------------------------------------------
interface bpred_fetch_mems_if #(
  parameter int INSN_AW = 8,
  parameter int INSN_DW = 32,
  parameter int BTB_AW  = 8,
  parameter int BTB_DW  = 36,
  parameter int BTB_NBE = 4
);
  logic               insn_wren;
  logic [INSN_AW-1:0] insn_wraddress;
  logic [INSN_DW-1:0] insn_data;
  logic [INSN_AW-1:0] insn_rdaddress;
  logic [INSN_DW-1:0] insn_q;

  logic               btb_wren;
  logic [BTB_NBE-1:0] btb_byteena;
  logic [BTB_AW-1:0]  btb_wraddress;
  logic [BTB_DW-1:0]  btb_data;
  logic [BTB_AW-1:0]  btb_rdaddress;
  logic [BTB_DW-1:0]  btb_q;

  modport master (
    output insn_wren, insn_wraddress, insn_data, insn_rdaddress,
    output btb_wren, btb_byteena, btb_wraddress, btb_data, btb_rdaddress,
    input  insn_q, btb_q
  );

  modport slave (
    input  insn_wren, insn_wraddress, insn_data, insn_rdaddress,
    input  btb_wren, btb_byteena, btb_wraddress, btb_data, btb_rdaddress,
    output insn_q, btb_q
  );
endinterface

// File: rtl/bpred_fetch_mems.sv
// ----------------------------------------------------------------------------
// bpred_fetch_mems
//   Storage for the branch-predictor fetch stage. The block contains two
//   simple dual-port RAMs on one clock:
//     - The instruction RAM has 2^INSN_AW words of INSN_DW bits. The
//       predictor indexes it with PC[9:2].
//     - The BTB/bimodal RAM has 2^BTB_AW entries of BTB_DW bits. Each entry
//       is laid out as [35:6] target[31:2], [5:4] bimodal counter and
//       [3:0] carry bits. The BTB write port has BTB_NBE lane enables of
//       BTB_DW/BTB_NBE bits each.
//   Each RAM has one write port and one registered read port. Reads have a
//   latency of one cycle and no read enable.
//
//   Ports:
//     clk    in  single clock, rising edge
//     reset  in  asynchronous, active-high. It clears only the two read-data
//                registers. The RAM contents are untouched, and writes are
//                still accepted while reset is asserted so that the
//                predictor can sweep-clear its bimodal lanes.
//     mem    slave side of bpred_fetch_mems_if (write ports, read addresses,
//            read data)
//
//   The array contents power up as zero through device RAM initialisation.
//   Because reset never touches the arrays, the only way to change stored
//   data is through the write ports.
// ----------------------------------------------------------------------------
module bpred_fetch_mems #(
  parameter int INSN_AW = 8,
  parameter int INSN_DW = 32,
  parameter int BTB_AW  = 8,
  parameter int BTB_DW  = 36,
  parameter int BTB_NBE = 4
) (
  input  logic                clk,
  input  logic                reset,
  bpred_fetch_mems_if.slave   mem
);

  localparam int INSN_DEPTH = 1 << INSN_AW;
  localparam int BTB_DEPTH  = 1 << BTB_AW;
  localparam int LANE_W     = BTB_DW / BTB_NBE;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [INSN_DW-1:0] insn_mem_q [INSN_DEPTH];
  logic [BTB_DW-1:0]  btb_mem_q  [BTB_DEPTH];

  // Registered read data and the value it will take at the next edge
  logic [INSN_DW-1:0] insn_rd_q, insn_rd_d;
  logic [BTB_DW-1:0]  btb_rd_q,  btb_rd_d;

  // --------------------------------------------------------------------------
  // Write ports
  // These blocks have no reset. The arrays must survive reset, and the
  // reset-time sweep depends on writes taking effect while reset is high.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem.insn_wren) begin
      insn_mem_q[mem.insn_wraddress] <= mem.insn_data;
    end
  end

  // Each lane is written independently, so that a partial update (for
  // example bimodal-only) leaves the other lanes of the entry intact. When
  // wren is high and no lane enable is set, nothing is written.
  always_ff @(posedge clk) begin
    if (mem.btb_wren) begin
      for (int i = 0; i < BTB_NBE; i++) begin
        if (mem.btb_byteena[i]) begin
          btb_mem_q[mem.btb_wraddress][i*LANE_W +: LANE_W] <=
            mem.btb_data[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // The array is sampled before this edge's write lands. A read that hits
  // the same address as a write on the same edge therefore returns the old
  // contents, and the new value is visible from the following edge onward.
  // --------------------------------------------------------------------------
  always_comb begin
    insn_rd_d = insn_mem_q[mem.insn_rdaddress];
    btb_rd_d  = btb_mem_q[mem.btb_rdaddress];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      insn_rd_q <= '0;
      btb_rd_q  <= '0;
    end else begin
      insn_rd_q <= insn_rd_d;
      btb_rd_q  <= btb_rd_d;
    end
  end

  assign mem.insn_q = insn_rd_q;
  assign mem.btb_q  = btb_rd_q;

endmodule

// File: tb/tb_bpred_fetch_mems.sv
module tb_bpred_fetch_mems;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bpred_fetch_mems_if bus ();

  bpred_fetch_mems dut (
    .clk   (clk),
    .reset (reset),
    .mem   (bus)
  );

  // --------------------------------------------------------------------------
  // Reference model: plain arrays holding the contents the RAMs should have
  // --------------------------------------------------------------------------
  logic [31:0] insn_m [256];
  logic [35:0] btb_m  [256];

  logic [31:0] exp_i_q [$];
  logic [35:0] exp_b_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  // Lane-masked merge: every enabled 9-bit lane takes the new data, and
  // every other lane keeps the old value.
  function automatic logic [35:0] merge(logic [35:0] old, logic [35:0] d,
                                        logic [3:0] be);
    logic [35:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m = m | (36'h1FF << (9 * i));
    end
    return (old & ~m) | (d & m);
  endfunction

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic drive(input logic iw, input logic [7:0] iwa, input logic [31:0] id,
                       input logic [7:0] ira, input logic bw, input logic [3:0] be,
                       input logic [7:0] bwa, input logic [35:0] bd,
                       input logic [7:0] bra);
    bus.insn_wren      = iw;
    bus.insn_wraddress = iwa;
    bus.insn_data      = id;
    bus.insn_rdaddress = ira;
    bus.btb_wren       = bw;
    bus.btb_byteena    = be;
    bus.btb_wraddress  = bwa;
    bus.btb_data       = bd;
    bus.btb_rdaddress  = bra;
  endtask

  // Waits for one rising edge, applies that edge's writes to the model, and
  // then settles to a sample point 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    if (bus.insn_wren) insn_m[bus.insn_wraddress] = bus.insn_data;
    if (bus.btb_wren)
      btb_m[bus.btb_wraddress] = merge(btb_m[bus.btb_wraddress], bus.btb_data,
                                       bus.btb_byteena);
    #1;
  endtask

  // Predicts the read data from the model contents before the edge (this is
  // what gives old-data semantics), steps one edge, and compares.
  task automatic step_check(input string name);
    exp_i_q.push_back(reset ? 32'h0 : insn_m[bus.insn_rdaddress]);
    exp_b_q.push_back(reset ? 36'h0 : btb_m[bus.btb_rdaddress]);
    step();
    check({name, "_insn_q"}, 64'(bus.insn_q), 64'(exp_i_q.pop_front()));
    check({name, "_btb_q"},  64'(bus.btb_q),  64'(exp_b_q.pop_front()));
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic        iw;
    logic [7:0]  iwa;
    logic [31:0] id;
    logic [7:0]  ira;
    logic        bw;
    logic [3:0]  be;
    logic [7:0]  bwa;
    logic [35:0] bd;
    logic [7:0]  bra;
    logic [31:0] exp_i;
    logic [35:0] exp_b;
    string       name;
  } vec_t;

  vec_t vecs [7];

  initial begin
    // Vectors: each row is applied for one edge, and the expected values
    // are the read data sampled after that edge.
    vecs[0] = '{1'b1, 8'h05, 32'hDEADBEEF, 8'h05, 1'b1, 4'hF, 8'h10, 36'hABCDE1234, 8'h10,
                32'h0, 36'h0, "v0_rdw_old"};
    vecs[1] = '{1'b0, 8'h00, 32'h0, 8'h05, 1'b1, 4'h1, 8'h10, 36'h0000001FF, 8'h10,
                32'hDEADBEEF, 36'hABCDE1234, "v1_full_word"};
    // In the next row, lane 0 (bits 8:0) becomes 0x1FF and bit 9 of 0x1234
    // stays set, so the entry reads back as ...13FF.
    vecs[2] = '{1'b0, 8'h00, 32'h0, 8'h05, 1'b0, 4'h0, 8'h00, 36'h0, 8'h10,
                32'hDEADBEEF, 36'hABCDE13FF, "v2_lane0"};
    vecs[3] = '{1'b1, 8'hFF, 32'h11111111, 8'hFF, 1'b1, 4'hF, 8'h20, 36'h123456789, 8'h20,
                32'h0, 36'h0, "v3_same_edge"};
    vecs[4] = '{1'b1, 8'h00, 32'h22222222, 8'hFF, 1'b0, 4'h0, 8'h00, 36'h0, 8'h20,
                32'h11111111, 36'h123456789, "v4_wrap_ff"};
    vecs[5] = '{1'b0, 8'h00, 32'h0, 8'h00, 1'b1, 4'h0, 8'h20, 36'hFFFFFFFFF, 8'h20,
                32'h22222222, 36'h123456789, "v5_be0"};
    vecs[6] = '{1'b0, 8'h00, 32'h0, 8'hFF, 1'b0, 4'h0, 8'h00, 36'h0, 8'h20,
                32'h11111111, 36'h123456789, "v6_be0_rb"};

    for (int a = 0; a < 256; a++) begin
      insn_m[a] = '0;
      btb_m[a]  = '0;
    end

    // Reset state
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("reset_insn_q", 64'(bus.insn_q), 64'h0);
    check("reset_btb_q",  64'(bus.btb_q),  64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven directed vectors
    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].iw, vecs[v].iwa, vecs[v].id, vecs[v].ira, vecs[v].bw,
            vecs[v].be, vecs[v].bwa, vecs[v].bd, vecs[v].bra);
      step();
      check({vecs[v].name, "_insn"}, 64'(bus.insn_q), 64'(vecs[v].exp_i));
      check({vecs[v].name, "_btb"},  64'(bus.btb_q),  64'(vecs[v].exp_b));
    end

    // Asynchronous reset in mid-cycle: the outputs must drop with no edge
    check("pre_reset_insn", 64'(bus.insn_q), 64'h11111111);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_insn", 64'(bus.insn_q), 64'h0);
    check("async_reset_btb",  64'(bus.btb_q),  64'h0);

    // Bimodal sweep during reset clears lane 0 of every entry
    for (int a = 0; a < 256; a++) begin
      drive(0, 0, 0, 8'h05, 1, 4'h1, 8'(a), 36'h0, 8'h20);
      step();
      check("sweep_hold_insn", 64'(bus.insn_q), 64'h0);
      check("sweep_hold_btb",  64'(bus.btb_q),  64'h0);
    end
    drive(0, 0, 0, 8'h05, 0, 4'h0, 0, 0, 8'h20);
    reset = 1'b0;
    #1;
    check("release_no_edge_btb", 64'(bus.btb_q), 64'h0);
    step();
    check("post_reset_insn", 64'(bus.insn_q), 64'hDEADBEEF);
    check("post_sweep_20",   64'(bus.btb_q),  64'h123456600);
    drive(0, 0, 0, 8'hFF, 0, 4'h0, 0, 0, 8'h10);
    step();
    check("post_sweep_ff_insn", 64'(bus.insn_q), 64'h11111111);
    check("post_sweep_10",      64'(bus.btb_q),  64'hABCDE1200);

    // Randomized traffic, checked against the model. Read addresses often
    // collide with the write address to exercise read-during-write.
    for (int n = 0; n < 600; n++) begin
      logic [7:0] iwa, bwa, ira, bra;
      iwa = 8'($urandom_range(0, 255));
      bwa = 8'($urandom_range(0, 255));
      ira = ($urandom_range(0, 3) == 0) ? iwa : 8'($urandom_range(0, 255));
      bra = ($urandom_range(0, 3) == 0) ? bwa : 8'($urandom_range(0, 255));
      drive(1'($urandom_range(0, 1)), iwa, $urandom, ira,
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), bwa,
            {4'($urandom), 32'($urandom)}, bra);
      step_check("rand");
    end

    // Full readback of both arrays
    for (int a = 0; a < 256; a++) begin
      drive(0, 0, 0, 8'(a), 0, 4'h0, 0, 0, 8'(a));
      step_check("readback");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
